lsu_mem_stage: RTL and testbench
================================

# lsu_mem_stage

Memory-stage load/store unit for the RV32I multicycle core. It accepts one decoded load or store from execute via a valid/ready handshake and drives the word-aligned data-memory port with byte masks. It waits for the memory response, then aligns and sign- or zero-extends load data. It returns a single-cycle writeback result to the register-file/writeback stage, or flags an error for misaligned accesses and illegal funct3 values.

## Interface
- No parameters; XLEN fixed at 32.
- clk  in  1  core clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  execute presents a memory op.
- req_ready  out  1  unit can accept (high only in IDLE).
- req_is_store  in  1  1 = store (opcode op_b_store), 0 = load (op_b_load).
- req_funct3  in  3  load_f3_t / store_f3_t encoding.
- req_addr  in  32  effective address rs1+imm.
- req_wdata  in  32  rs2 value (stores).
- req_rd  in  5  destination register (loads).
- dmem_addr  out  32  {addr[31:2],2'b00}.
- dmem_rmask  out  4  byte read enables.
- dmem_wmask  out  4  byte write enables.
- dmem_wdata  out  32  lane-shifted store data.
- dmem_rdata  in  32  read word, valid with dmem_resp.
- dmem_resp  in  1  one-cycle completion pulse.
- resp_valid  out  1  one-cycle result pulse.
- resp_we  out  1  write rd (load, no error, rd≠0).
- resp_rd  out  5  destination register.
- resp_data  out  32  extended load data; 0 for stores/errors.
- resp_err  out  1  misaligned or illegal funct3.

## Operation
- FSM states: IDLE, WAIT, RESP. Reset → IDLE.
- IDLE: req_ready=1. On req_valid, latch request fields.
  - If the request is legal and aligned → WAIT.
  - Otherwise → RESP with err=1.
- WAIT: dmem_addr/masks/wdata are registered outputs, held constant until dmem_resp. On dmem_resp, capture rdata → RESP.
- RESP: resp_valid=1 for exactly one cycle, then → IDLE. Masks are 0 in RESP and IDLE.
- Byte masks, with o = addr[1:0]:
  - byte: 4'b0001<<o
  - half: 4'b0011<<o
  - word: 4'b1111
- Loads drive rmask only (wmask=0). Stores drive wmask only (rmask=0).
- Store data: dmem_wdata = req_wdata << (8*o). Bytes outside the mask are don't-care.
- Load data: shift the captured word right by 8*o, then:
  - lb: sext[7:0]; lbu: zext[7:0]
  - lh: sext[15:0]; lhu: zext[15:0]
  - lw: the full word
- Alignment rules:
  - Halfword with o[0]=1 → error.
  - Word with o≠0 → error.
  - Byte is always aligned.
- Illegal funct3 → error:
  - Loads: 011, 110, 111.
  - Stores: any value ≥ 011.
- An errored request issues no dmem access (masks stay 0). Its result is resp_err=1, resp_we=0, resp_data=0.
- Stores complete with resp_valid=1, resp_we=0, resp_data=0.
- A load with rd=0 completes with resp_we=0 and resp_data set to the extended value.
- dmem_resp in IDLE or RESP is ignored.
- Back-to-back requests: a new request is accepted only in IDLE, so at most one op is outstanding.

## Timing
- Reset values: req_ready=1, resp_valid=0, resp_we=0, resp_err=0, resp_rd=0, resp_data=0, dmem_addr=0, dmem_rmask=0, dmem_wmask=0, dmem_wdata=0.
- Handshake at cycle T (req_valid & req_ready):
  - T+1: masks valid on the dmem port.
  - dmem_resp arrives at T+k, k≥1 (k=1 allowed).
  - T+k+1: resp_valid.
  - T+k+2: back in IDLE, req_ready=1.
- Minimum latency accept→result is 2 cycles. Error path: accept at T, resp_valid at T+1, req_ready at T+2.
- Outputs are registered. There are no combinational paths from dmem_rdata/dmem_resp to resp_* or from req_* to dmem_*.
- req_valid while req_ready=0 is ignored. Upstream holds the request.
- Reset asserted in any state:
  - The next cycle is IDLE with all outputs at reset values.
  - An in-flight access is abandoned.
  - A dmem_resp arriving after reset is ignored.
- resp_valid has no backpressure. The consumer must accept it in that cycle.

## Test plan
- lw addr=0x1000, dmem_rdata=0xDEADBEEF, resp at T+1:
  - T+1: rmask=1111, dmem_addr=0x1000.
  - T+2: resp_valid, resp_data=0xDEADBEEF, resp_we=1.
- lb addr=0x2003 and lbu addr=0x2003 with rdata=0x80112233:
  - lb → resp_data=0xFFFFFF80, rmask=1000.
  - lbu → resp_data=0x00000080.
- sh addr=0x3002, wdata=0x0000ABCD, resp after 5 cycles:
  - wmask=1100 and dmem_wdata[31:16]=0xABCD held for all 5 wait cycles.
  - Then resp_valid=1, resp_we=0.
- lw addr=0x1001; sh addr=0x0003; load funct3=011:
  - Each gives no mask activity, resp_valid at T+1, resp_err=1, resp_data=0.
- rst asserted mid-WAIT, then a late dmem_resp:
  - Masks are 0 the cycle after reset; no resp_valid; req_ready=1.
  - A new lhu addr=0x10 with rdata=0xFFFF0000 → resp_data=0x00000000.
  - A following lh addr=0x12 → resp_data=0xFFFFFFFF.
- Load with rd=0: resp_valid=1, resp_we=0.

Source files
------------

// File: rtl/lsu_mem_stage.sv
`default_nettype none
// ============================================================================
// Module   : lsu_mem_stage
// Purpose  : RV32I memory-stage load/store unit. Accepts one load or store
//            from execute, drives a word-aligned data-memory port with byte
//            masks, waits for the response, then aligns and extends the
//            load data into a single-cycle writeback result. Misaligned
//            accesses and illegal funct3 values skip memory and report
//            resp_err instead.
// Ports    : clk, rst (sync, active-high)
//            req_*  : execute request (valid/ready, is_store, funct3,
//                     addr, wdata, rd)
//            dmem_* : word address, read/write byte masks, lane-shifted
//                     write data, read data and one-cycle response pulse
//            resp_* : one-cycle writeback pulse (we, rd, data, err)
// Revision : 1.0 - initial release
// ============================================================================
module lsu_mem_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_is_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [4:0]  req_rd,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_rmask,
  output logic [3:0]  dmem_wmask,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_resp,
  output logic        resp_valid,
  output logic        resp_we,
  output logic [4:0]  resp_rd,
  output logic [31:0] resp_data,
  output logic        resp_err
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  logic [1:0]  state_q, state_d;
  logic        is_store_q, is_store_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [1:0]  off_q, off_d;
  logic [4:0]  rd_q, rd_d;
  logic [31:0] dmem_addr_q, dmem_addr_d;
  logic [3:0]  dmem_rmask_q, dmem_rmask_d;
  logic [3:0]  dmem_wmask_q, dmem_wmask_d;
  logic [31:0] dmem_wdata_q, dmem_wdata_d;
  logic        resp_valid_q, resp_valid_d;
  logic        resp_we_q, resp_we_d;
  logic [4:0]  resp_rd_q, resp_rd_d;
  logic [31:0] resp_data_q, resp_data_d;
  logic        resp_err_q, resp_err_d;

  // Request decode (only consumed while IDLE)
  logic [1:0] w_off;
  logic       w_f3_legal;
  logic       w_misaligned;
  logic       w_req_ok;
  logic [3:0] w_mask;

  assign w_off = req_addr[1:0];

  always_comb begin
    w_f3_legal   = 1'b0;
    w_misaligned = 1'b0;
    w_mask       = 4'b0000;
    if (req_is_store) begin
      w_f3_legal = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) ||
                   (req_funct3 == 3'b010);
    end else begin
      w_f3_legal = (req_funct3 != 3'b011) && (req_funct3 != 3'b110) &&
                   (req_funct3 != 3'b111);
    end
    // funct3[1:0] encodes the access size for both loads and stores
    case (req_funct3[1:0])
      2'b00: w_mask = 4'b0001 << w_off;
      2'b01: begin
        w_mask       = 4'b0011 << w_off;
        w_misaligned = w_off[0];
      end
      2'b10: begin
        w_mask       = 4'b1111;
        w_misaligned = (w_off != 2'b00);
      end
      default: w_mask = 4'b0000;
    endcase
  end

  assign w_req_ok = w_f3_legal && !w_misaligned;

  // Shift the returned word down to lane 0 and extend per load type
  function automatic logic [31:0] load_extend(input logic [31:0] word,
                                               input logic [1:0]  off,
                                               input logic [2:0]  f3);
    logic [31:0] s;
    s = word >> {off, 3'b000};
    case (f3)
      3'b000:  load_extend = {{24{s[7]}}, s[7:0]};
      3'b100:  load_extend = {24'd0, s[7:0]};
      3'b001:  load_extend = {{16{s[15]}}, s[15:0]};
      3'b101:  load_extend = {16'd0, s[15:0]};
      3'b010:  load_extend = s;
      default: load_extend = 32'd0;
    endcase
  endfunction

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      is_store_q   <= 1'b0;
      funct3_q     <= 3'd0;
      off_q        <= 2'd0;
      rd_q         <= 5'd0;
      dmem_addr_q  <= 32'd0;
      dmem_rmask_q <= 4'd0;
      dmem_wmask_q <= 4'd0;
      dmem_wdata_q <= 32'd0;
      resp_valid_q <= 1'b0;
      resp_we_q    <= 1'b0;
      resp_rd_q    <= 5'd0;
      resp_data_q  <= 32'd0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      is_store_q   <= is_store_d;
      funct3_q     <= funct3_d;
      off_q        <= off_d;
      rd_q         <= rd_d;
      dmem_addr_q  <= dmem_addr_d;
      dmem_rmask_q <= dmem_rmask_d;
      dmem_wmask_q <= dmem_wmask_d;
      dmem_wdata_q <= dmem_wdata_d;
      resp_valid_q <= resp_valid_d;
      resp_we_q    <= resp_we_d;
      resp_rd_q    <= resp_rd_d;
      resp_data_q  <= resp_data_d;
      resp_err_q   <= resp_err_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (req_valid) state_d = w_req_ok ? ST_WAIT : ST_RESP;
      ST_WAIT: if (dmem_resp) state_d = ST_RESP;
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output / datapath next values; resp_* default to zero so they only
  // carry information during the one-cycle pulse.
  always_comb begin
    is_store_d   = is_store_q;
    funct3_d     = funct3_q;
    off_d        = off_q;
    rd_d         = rd_q;
    dmem_addr_d  = dmem_addr_q;
    dmem_rmask_d = dmem_rmask_q;
    dmem_wmask_d = dmem_wmask_q;
    dmem_wdata_d = dmem_wdata_q;
    resp_valid_d = 1'b0;
    resp_we_d    = 1'b0;
    resp_rd_d    = 5'd0;
    resp_data_d  = 32'd0;
    resp_err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          is_store_d = req_is_store;
          funct3_d   = req_funct3;
          off_d      = w_off;
          rd_d       = req_rd;
          if (w_req_ok) begin
            dmem_addr_d  = {req_addr[31:2], 2'b00};
            dmem_rmask_d = req_is_store ? 4'b0000 : w_mask;
            dmem_wmask_d = req_is_store ? w_mask : 4'b0000;
            dmem_wdata_d = req_wdata << {w_off, 3'b000};
          end else begin
            // Errored request: no memory access, straight to result
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
            resp_rd_d    = req_rd;
          end
        end
      end
      ST_WAIT: begin
        if (dmem_resp) begin
          dmem_rmask_d = 4'b0000;
          dmem_wmask_d = 4'b0000;
          resp_valid_d = 1'b1;
          resp_rd_d    = rd_q;
          resp_we_d    = !is_store_q && (rd_q != 5'd0);
          resp_data_d  = is_store_q ? 32'd0
                                    : load_extend(dmem_rdata, off_q, funct3_q);
        end
      end
      default: begin
        dmem_rmask_d = 4'b0000;
        dmem_wmask_d = 4'b0000;
      end
    endcase
  end

  assign req_ready  = (state_q == ST_IDLE);
  assign dmem_addr  = dmem_addr_q;
  assign dmem_rmask = dmem_rmask_q;
  assign dmem_wmask = dmem_wmask_q;
  assign dmem_wdata = dmem_wdata_q;
  assign resp_valid = resp_valid_q;
  assign resp_we    = resp_we_q;
  assign resp_rd    = resp_rd_q;
  assign resp_data  = resp_data_q;
  assign resp_err   = resp_err_q;

endmodule
`default_nettype wire

// File: tb/tb_lsu_mem_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_lsu_mem_stage
// Purpose  : Directed scoreboard bench for lsu_mem_stage. Stimulus pushes
//            the hand-computed expected result of each op into a queue; a
//            monitor pops and compares whenever resp_valid is seen.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lsu_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_is_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [4:0]  req_rd;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_rmask;
  logic [3:0]  dmem_wmask;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_resp;
  logic        resp_valid;
  logic        resp_we;
  logic [4:0]  resp_rd;
  logic [31:0] resp_data;
  logic        resp_err;

  lsu_mem_stage dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_is_store (req_is_store),
    .req_funct3   (req_funct3),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .req_rd       (req_rd),
    .dmem_addr    (dmem_addr),
    .dmem_rmask   (dmem_rmask),
    .dmem_wmask   (dmem_wmask),
    .dmem_wdata   (dmem_wdata),
    .dmem_rdata   (dmem_rdata),
    .dmem_resp    (dmem_resp),
    .resp_valid   (resp_valid),
    .resp_we      (resp_we),
    .resp_rd      (resp_rd),
    .resp_data    (resp_data),
    .resp_err     (resp_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        we;
    logic        err;
    logic [4:0]  rd;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: compare every result pulse against the scoreboard head
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (resp_valid) begin
        if (sb.size() == 0) begin
          check("unexpected_resp", 64'(resp_valid), 64'd0);
        end else begin
          e = sb.pop_front();
          check("resp_we_err", 64'({resp_we, resp_err}), 64'({e.we, e.err}));
          check("resp_data", 64'(resp_data), 64'(e.data));
          if (e.we) check("resp_rd", 64'(resp_rd), 64'(e.rd));
        end
      end
    end
  end

  task automatic push(input logic we, input logic err, input logic [4:0] rd,
                      input logic [31:0] data);
    exp_t e;
    e.we = we; e.err = err; e.rd = rd; e.data = data;
    sb.push_back(e);
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 20 && !req_ready; i++) begin
      @(posedge clk); #1;
    end
    check("ready_timeout", 64'(req_ready), 64'd1);
  endtask

  // Handshake; returns 1ns into cycle T+1
  task automatic issue(input logic st, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic [4:0] rd);
    wait_ready();
    req_valid = 1'b1; req_is_store = st; req_funct3 = f3;
    req_addr = a; req_wdata = wd; req_rd = rd;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  // Checks the dmem port every wait cycle, responds in the k-th cycle,
  // then checks the result pulse is present in the following cycle.
  task automatic mem_reply(input int k, input logic [31:0] rdata,
                           input logic [31:0] ea, input logic [3:0] erm,
                           input logic [3:0] ewm, input logic [31:0] ewd);
    logic [31:0] lane;
    lane = {{8{ewm[3]}}, {8{ewm[2]}}, {8{ewm[1]}}, {8{ewm[0]}}};
    for (int i = 0; i < k; i++) begin
      check("dmem_port", 64'({dmem_addr, dmem_rmask, dmem_wmask}),
            64'({ea, erm, ewm}));
      check("dmem_wdata", 64'(dmem_wdata & lane), 64'(ewd & lane));
      if (i == k - 1) begin
        dmem_resp = 1'b1; dmem_rdata = rdata;
      end
      @(posedge clk); #1;
      dmem_resp = 1'b0;
    end
    check("resp_timing", 64'(resp_valid), 64'd1);
  endtask

  task automatic load_op(input logic [2:0] f3, input logic [31:0] a,
                         input logic [4:0] rd, input logic [31:0] rdata,
                         input int k, input logic [3:0] erm,
                         input logic [31:0] edata);
    push(rd != 5'd0, 1'b0, rd, edata);
    issue(1'b0, f3, a, 32'h0, rd);
    mem_reply(k, rdata, {a[31:2], 2'b00}, erm, 4'b0000, 32'h0);
  endtask

  task automatic store_op(input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input int k,
                          input logic [3:0] ewm, input logic [31:0] ewd);
    push(1'b0, 1'b0, 5'd0, 32'h0);
    issue(1'b1, f3, a, wd, 5'd0);
    mem_reply(k, 32'h0, {a[31:2], 2'b00}, 4'b0000, ewm, ewd);
  endtask

  task automatic err_op(input logic st, input logic [2:0] f3,
                        input logic [31:0] a, input logic [4:0] rd);
    push(1'b0, 1'b1, rd, 32'h0);
    issue(st, f3, a, 32'hFFFF_FFFF, rd);
    check("err_masks", 64'({dmem_rmask, dmem_wmask}), 64'd0);
    check("err_timing", 64'({resp_valid, req_ready}), 64'b10);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_is_store = 1'b0; req_funct3 = 3'd0;
    req_addr = 32'h0; req_wdata = 32'h0; req_rd = 5'd0;
    dmem_rdata = 32'h0; dmem_resp = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ctrl", 64'({req_ready, resp_valid, resp_we, resp_err, resp_rd}),
          64'({1'b1, 1'b0, 1'b0, 1'b0, 5'd0}));
    check("reset_data", 64'(resp_data), 64'd0);
    check("reset_dmem", 64'({dmem_addr, dmem_rmask, dmem_wmask}), 64'd0);
    check("reset_wdata", 64'(dmem_wdata), 64'd0);
    rst = 1'b0;

    // Word / byte loads
    load_op(3'b010, 32'h0000_1000, 5'd5, 32'hDEAD_BEEF, 1, 4'b1111, 32'hDEAD_BEEF);
    load_op(3'b000, 32'h0000_2003, 5'd6, 32'h8011_2233, 1, 4'b1000, 32'hFFFF_FF80);
    load_op(3'b100, 32'h0000_2003, 5'd7, 32'h8011_2233, 2, 4'b1000, 32'h0000_0080);
    load_op(3'b001, 32'h0000_1002, 5'd8, 32'h7FFF_1234, 1, 4'b1100, 32'h0000_7FFF);
    load_op(3'b000, 32'h0000_2001, 5'd9, 32'h0000_9C00, 1, 4'b0010, 32'hFFFF_FF9C);

    // Stores
    store_op(3'b001, 32'h0000_3002, 32'h0000_ABCD, 5, 4'b1100, 32'hABCD_0000);
    store_op(3'b000, 32'h0000_4001, 32'h0000_00A5, 1, 4'b0010, 32'h0000_A500);
    store_op(3'b010, 32'h0000_4000, 32'h1234_5678, 3, 4'b1111, 32'h1234_5678);

    // Error paths
    err_op(1'b0, 3'b010, 32'h0000_1001, 5'd3);
    err_op(1'b1, 3'b001, 32'h0000_0003, 5'd0);
    err_op(1'b0, 3'b011, 32'h0000_0100, 5'd4);
    err_op(1'b0, 3'b101, 32'h0000_0005, 5'd4);
    err_op(1'b1, 3'b011, 32'h0000_0200, 5'd0);
    err_op(1'b0, 3'b110, 32'h0000_0200, 5'd2);

    // Reset mid-WAIT, then a late response that must be ignored
    issue(1'b0, 3'b010, 32'h0000_0040, 32'h0, 5'd3);
    check("pre_rst_mask", 64'(dmem_rmask), 64'b1111);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("post_rst", 64'({dmem_rmask, dmem_wmask, resp_valid, req_ready}),
          64'({4'b0000, 4'b0000, 1'b0, 1'b1}));
    dmem_resp = 1'b1; dmem_rdata = 32'h1111_1111;
    @(posedge clk); #1;
    dmem_resp = 1'b0;
    check("late_resp_ignored", 64'({resp_valid, req_ready}), 64'b01);

    load_op(3'b101, 32'h0000_0010, 5'd10, 32'hFFFF_0000, 1, 4'b0011, 32'h0000_0000);
    load_op(3'b001, 32'h0000_0012, 5'd11, 32'hFFFF_0000, 1, 4'b1100, 32'hFFFF_FFFF);

    // Load to x0: no write-enable, data still returned
    load_op(3'b010, 32'h0000_0020, 5'd0, 32'h0000_0055, 2, 4'b1111, 32'h0000_0055);

    repeat (3) @(posedge clk);
    #1;
    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
